// File: rtl/spr_ctrl_pkg.sv
// Shared opcodes, FSM state type and default widths for the single-port RAM arbiter.
// Imported by spr_arbiter and rr_arbiter.
package spr_ctrl_pkg;

    localparam int DEF_NUM_REQ   = 2;
    localparam int DEF_ADDR_SIZE = 8;

    // Upper two bits of the RAM command word
    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_e;

    // Width of a requester index; at least one bit so a 1-requester build stays legal
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spr_arbiter_rr.sv
// Combinational round-robin picker: first set req bit at or after ptr+1 (mod NUM_REQ).
// Module rr_arbiter, instantiated by spr_arbiter.
module rr_arbiter
    import spr_ctrl_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx
);

    int   cand;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        cand  = 0;
        found = 1'b0;
        // Offset NUM_REQ wraps back to ptr itself, so the last winner is lowest priority
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/spr_arbiter.sv
// Round-robin share of one single-port RAM command port among NUM_REQ requesters.
// Optional address-shadow cache enabled by defining SPR_ADDR_CACHE_EN.
//
// state | meaning
// IDLE  | arbitrate; gnt pulses combinationally for the winner
// ADDR  | issue address command (skipped on a shadow hit)
// DATA  | issue write-data or read command
// RESP  | done pulse to winner, read data / rd_err returned
module spr_arbiter
    import spr_ctrl_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           req_we,
    input  logic [NUM_REQ*ADDR_SIZE-1:0] req_addr,
    input  logic [NUM_REQ*ADDR_SIZE-1:0] req_wdata,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           done,
    output logic [ADDR_SIZE-1:0]         rdata,
    output logic                         rd_err,
    output logic                         busy,
    output logic [ADDR_SIZE+1:0]         ram_din,
    output logic                         ram_rx_valid,
    input  logic [ADDR_SIZE-1:0]         ram_dout,
    input  logic                         ram_tx_valid
);

    localparam int IW = idx_width(NUM_REQ);

    state_e                state, state_nxt;
    logic [IW-1:0]         ptr;
    logic                  cur_we;
    logic [ADDR_SIZE-1:0]  cur_addr;
    logic [ADDR_SIZE-1:0]  cur_wdata;

    logic [NUM_REQ-1:0]    arb_gnt;
    logic [IW-1:0]         arb_idx;
    logic                  win_we;
    logic [ADDR_SIZE-1:0]  win_addr;
    logic [ADDR_SIZE-1:0]  win_wdata;
    logic                  any_req;
    logic                  cache_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign any_req   = |req;
    assign win_we    = req_we[arb_idx];
    assign win_addr  = req_addr[int'(arb_idx)*ADDR_SIZE +: ADDR_SIZE];
    assign win_wdata = req_wdata[int'(arb_idx)*ADDR_SIZE +: ADDR_SIZE];

`ifdef SPR_ADDR_CACHE_EN
    logic [ADDR_SIZE-1:0] wr_shadow;
    logic [ADDR_SIZE-1:0] rd_shadow;
    logic                 wr_shadow_vld;
    logic                 rd_shadow_vld;

    // Shadows track what the RAM's address latches currently hold, per direction
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_shadow     <= '0;
            rd_shadow     <= '0;
            wr_shadow_vld <= 1'b0;
            rd_shadow_vld <= 1'b0;
        end else if (state == ADDR) begin
            if (cur_we) begin
                wr_shadow     <= cur_addr;
                wr_shadow_vld <= 1'b1;
            end else begin
                rd_shadow     <= cur_addr;
                rd_shadow_vld <= 1'b1;
            end
        end
    end

    assign cache_hit = win_we ? (wr_shadow_vld && (wr_shadow == win_addr))
                              : (rd_shadow_vld && (rd_shadow == win_addr));
`else
    assign cache_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = cache_hit ? DATA : ADDR;
                end
            end
            ADDR:    state_nxt = DATA;
            DATA:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            ptr       <= IW'(NUM_REQ - 1);
            cur_we    <= 1'b0;
            cur_addr  <= '0;
            cur_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                ptr       <= arb_idx;
                cur_we    <= win_we;
                cur_addr  <= win_addr;
                cur_wdata <= win_wdata;
            end
        end
    end

    // RAM command decode uses only registered state and latched fields
    always_comb begin
        ram_rx_valid = 1'b0;
        ram_din      = '0;
        case (state)
            ADDR: begin
                ram_rx_valid = 1'b1;
                ram_din      = {(cur_we ? OP_WR_ADDR : OP_RD_ADDR), cur_addr};
            end
            DATA: begin
                ram_rx_valid = 1'b1;
                ram_din      = cur_we ? {OP_WR_DATA, cur_wdata}
                                      : {OP_RD_DATA, {ADDR_SIZE{1'b0}}};
            end
            default: begin
                ram_rx_valid = 1'b0;
                ram_din      = '0;
            end
        endcase
    end

    // rstn gates gnt because req can be high while the block is held in reset
    assign gnt    = (rstn && state == IDLE) ? arb_gnt : '0;
    assign busy   = (state != IDLE);
    assign done   = (state == RESP) ? (NUM_REQ'(1) << ptr) : '0;
    assign rdata  = (state == RESP && !cur_we) ? ram_dout : '0;
    assign rd_err = (state == RESP) && !cur_we && !ram_tx_valid;

endmodule
